// File: rtl/id_ex_issue.sv
// ID->EX issue stage: single-entry pipeline register between decode and
// execute with load-use hazard detection. A load sitting in the output
// register, or still in flight in the pending-load shift register, stalls a
// dependent consumer until its result can be forwarded. The hazard and
// in_ready outputs are intentionally combinational; all payload is registered.
module id_ex_issue #(
  parameter int XLEN     = 64,
  parameter int LOAD_LAT = 1,
  parameter int CTRL_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  // upstream (ID) handshake and payload
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_rs1,
  input  logic [XLEN-1:0]   in_rs2,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [4:0]        in_rs1_idx,
  input  logic [4:0]        in_rs2_idx,
  input  logic [4:0]        in_rd,
  input  logic              in_wben,
  input  logic              in_is_load,
  // kill from branch/jump resolution in EX
  input  logic              flush,
  // downstream (EX) handshake and registered payload
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1,
  output logic [XLEN-1:0]   out_rs2,
  output logic [XLEN-1:0]   out_imm,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [4:0]        out_rd,
  output logic              out_wben,
  output logic              out_is_load,
  // hazard status
  output logic              hazard,
  output logic [31:0]       stall_cnt
);

  // True when a producer writing rd feeds either source index of the
  // incoming instruction. Register 0 is never a real dependency.
  function automatic logic src_match(input logic [4:0] rd,
                                     input logic [4:0] rs1_idx,
                                     input logic [4:0] rs2_idx);
    return (rd != 5'd0) && ((rd == rs1_idx) || (rd == rs2_idx));
  endfunction

  // output pipeline register state
  logic              out_valid_r;
  logic [XLEN-1:0]   out_pc_r;
  logic [XLEN-1:0]   out_rs1_r;
  logic [XLEN-1:0]   out_rs2_r;
  logic [XLEN-1:0]   out_imm_r;
  logic [CTRL_W-1:0] out_ctrl_r;
  logic [4:0]        out_rd_r;
  logic              out_wben_r;
  logic              out_is_load_r;
  logic [31:0]       stall_cnt_r;

  // combinational control
  logic load_en_s;
  logic out_hit_s;
  logic pend_hit_s;
  logic hazard_s;
  logic in_ready_s;
  logic accept_s;
  logic head_v_s;

  assign out_valid   = out_valid_r;
  assign out_pc      = out_pc_r;
  assign out_rs1     = out_rs1_r;
  assign out_rs2     = out_rs2_r;
  assign out_imm     = out_imm_r;
  assign out_ctrl    = out_ctrl_r;
  assign out_rd      = out_rd_r;
  assign out_wben    = out_wben_r;
  assign out_is_load = out_is_load_r;
  assign stall_cnt   = stall_cnt_r;
  assign hazard      = hazard_s;
  assign in_ready    = in_ready_s;

  // Handshake and hazard decode; flush and reset both mask the stall so a
  // killed or discarded consumer never counts as stalled.
  always_comb begin
    load_en_s  = out_ready | ~out_valid_r;
    out_hit_s  = out_valid_r & out_is_load_r & out_wben_r &
                 src_match(out_rd_r, in_rs1_idx, in_rs2_idx);
    hazard_s   = ~rst & in_valid & ~flush & (out_hit_s | pend_hit_s);
    in_ready_s = ~rst & load_en_s & ~hazard_s & ~flush;
    accept_s   = in_valid & in_ready_s;
    // a flushed load never reaches writeback, so it must not enter pend
    head_v_s   = out_valid_r & out_is_load_r & out_wben_r &
                 (out_rd_r != 5'd0) & ~flush;
  end

  // Output register: capture on transfer, bubble when draining with no
  // input, hold under backpressure; flush empties it unconditionally.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r   <= 1'b0;
      out_pc_r      <= '0;
      out_rs1_r     <= '0;
      out_rs2_r     <= '0;
      out_imm_r     <= '0;
      out_ctrl_r    <= '0;
      out_rd_r      <= 5'd0;
      out_wben_r    <= 1'b0;
      out_is_load_r <= 1'b0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (load_en_s) begin
      out_valid_r <= accept_s;
      if (accept_s) begin
        out_pc_r      <= in_pc;
        out_rs1_r     <= in_rs1;
        out_rs2_r     <= in_rs2;
        out_imm_r     <= in_imm;
        out_ctrl_r    <= in_ctrl;
        out_rd_r      <= in_rd;
        out_wben_r    <= in_wben;
        out_is_load_r <= in_is_load;
      end
    end
  end

  // Stall cycle counter, saturating so long-running stats never wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 32'd0;
    end else if (hazard_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end
  end

  generate
    if (LOAD_LAT > 1) begin : g_pend
      // Loads that have left the output register but whose data is not yet
      // forwardable; the shift advances only when EX advances.
      logic [LOAD_LAT-2:0] pend_v_r;
      logic [4:0]          pend_rd_r [LOAD_LAT-1];

      // Pending-load shift register, advanced in lockstep with EX.
      always_ff @(posedge clk) begin
        if (rst) begin
          pend_v_r <= '0;
          for (int i = 0; i < LOAD_LAT - 1; i++) begin
            pend_rd_r[i] <= 5'd0;
          end
        end else if (out_ready) begin
          pend_v_r[0]  <= head_v_s;
          pend_rd_r[0] <= out_rd_r;
          for (int i = 1; i < LOAD_LAT - 1; i++) begin
            pend_v_r[i]  <= pend_v_r[i-1];
            pend_rd_r[i] <= pend_rd_r[i-1];
          end
        end
      end

      // Any in-flight load targeting a source register is a hazard.
      always_comb begin
        pend_hit_s = 1'b0;
        for (int i = 0; i < LOAD_LAT - 1; i++) begin
          if (pend_v_r[i] && src_match(pend_rd_r[i], in_rs1_idx, in_rs2_idx)) begin
            pend_hit_s = 1'b1;
          end else begin
            pend_hit_s = pend_hit_s;
          end
        end
      end
    end else begin : g_nopend
      assign pend_hit_s = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed bench for id_ex_issue. Three instances with LOAD_LAT = 1, 2, 3
// share clock and reset; each scenario drives one instance while the others
// idle. Inputs change just after the falling edge, checks sample there too.
module tb_id_ex_issue;
  localparam int XLEN   = 64;
  localparam int CTRL_W = 12;
  localparam int NI     = 3;

  logic clk = 1'b0;
  logic rst;

  logic              in_valid    [NI];
  logic              in_ready    [NI];
  logic [XLEN-1:0]   in_pc       [NI];
  logic [XLEN-1:0]   in_rs1      [NI];
  logic [XLEN-1:0]   in_rs2      [NI];
  logic [XLEN-1:0]   in_imm      [NI];
  logic [CTRL_W-1:0] in_ctrl     [NI];
  logic [4:0]        in_rs1_idx  [NI];
  logic [4:0]        in_rs2_idx  [NI];
  logic [4:0]        in_rd       [NI];
  logic              in_wben     [NI];
  logic              in_is_load  [NI];
  logic              flush       [NI];
  logic              out_valid   [NI];
  logic              out_ready   [NI];
  logic [XLEN-1:0]   out_pc      [NI];
  logic [XLEN-1:0]   out_rs1     [NI];
  logic [XLEN-1:0]   out_rs2     [NI];
  logic [XLEN-1:0]   out_imm     [NI];
  logic [CTRL_W-1:0] out_ctrl    [NI];
  logic [4:0]        out_rd      [NI];
  logic              out_wben    [NI];
  logic              out_is_load [NI];
  logic              hazard      [NI];
  logic [31:0]       stall_cnt   [NI];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    id_ex_issue #(.XLEN(XLEN), .LOAD_LAT(g + 1), .CTRL_W(CTRL_W)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_pc(in_pc[g]), .in_rs1(in_rs1[g]), .in_rs2(in_rs2[g]),
      .in_imm(in_imm[g]), .in_ctrl(in_ctrl[g]),
      .in_rs1_idx(in_rs1_idx[g]), .in_rs2_idx(in_rs2_idx[g]), .in_rd(in_rd[g]),
      .in_wben(in_wben[g]), .in_is_load(in_is_load[g]),
      .flush(flush[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_pc(out_pc[g]), .out_rs1(out_rs1[g]), .out_rs2(out_rs2[g]),
      .out_imm(out_imm[g]), .out_ctrl(out_ctrl[g]), .out_rd(out_rd[g]),
      .out_wben(out_wben[g]), .out_is_load(out_is_load[g]),
      .hazard(hazard[g]), .stall_cnt(stall_cnt[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic present(input int k, input logic [63:0] pc, input logic [4:0] rs1i,
                         input logic [4:0] rs2i, input logic [4:0] rd, input logic ld);
    in_valid[k]   = 1'b1;
    in_pc[k]      = pc;
    in_rs1[k]     = pc ^ 64'h5555_AAAA_5555_AAAA;
    in_rs2[k]     = ~pc;
    in_imm[k]     = pc + 64'd8;
    in_ctrl[k]    = pc[11:0] ^ 12'hA5A;
    in_rs1_idx[k] = rs1i;
    in_rs2_idx[k] = rs2i;
    in_rd[k]      = rd;
    in_wben[k]    = 1'b1;
    in_is_load[k] = ld;
  endtask

  task automatic idle(input int k);
    in_valid[k] = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] pcv;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      present(k, 64'h0, 5'd0, 5'd0, 5'd0, 1'b0);
      in_valid[k]  = 1'b0;
      flush[k]     = 1'b0;
      out_ready[k] = 1'b1;
    end
    step(); step();
    // during reset: nothing accepted, no hazard
    present(0, 64'h10, 5'd5, 5'd0, 5'd5, 1'b1);
    #1;
    chk("rst_in_ready", in_ready[0], 1'b0);
    chk("rst_hazard", hazard[0], 1'b0);
    chk("rst_out_valid", out_valid[0], 1'b0);
    chk("rst_out_pc", out_pc[0], 64'h0);
    chk("rst_stall_cnt", stall_cnt[0], 32'd0);
    rst = 1'b0;
    idle(0);

    // ---- LOAD_LAT=1: ld x5 ; add x6,x5,x7 ----
    step();
    present(0, 64'h100, 5'd1, 5'd0, 5'd5, 1'b1);
    #1 chk("l1_ld_ready", in_ready[0], 1'b1);
    step();
    chk("l1_ld_out_valid", out_valid[0], 1'b1);
    chk("l1_ld_out_pc", out_pc[0], 64'h100);
    pcv = 64'h100;
    chk("l1_ld_out_rs1", out_rs1[0], pcv ^ 64'h5555_AAAA_5555_AAAA);
    chk("l1_ld_out_imm", out_imm[0], 64'h108);
    chk("l1_ld_out_ctrl", out_ctrl[0], 12'h100 ^ 12'hA5A);
    chk("l1_ld_is_load", out_is_load[0], 1'b1);
    present(0, 64'h104, 5'd5, 5'd7, 5'd6, 1'b0);
    #1;
    chk("l1_hazard", hazard[0], 1'b1);
    chk("l1_stall_ready", in_ready[0], 1'b0);
    step();
    chk("l1_bubble", out_valid[0], 1'b0);
    chk("l1_stall_cnt", stall_cnt[0], 32'd1);
    chk("l1_hazard_clear", hazard[0], 1'b0);
    chk("l1_ready_again", in_ready[0], 1'b1);
    step();
    chk("l1_add_valid", out_valid[0], 1'b1);
    chk("l1_add_pc", out_pc[0], 64'h104);
    chk("l1_add_rd", out_rd[0], 5'd6);
    chk("l1_stall_cnt_final", stall_cnt[0], 32'd1);
    idle(0);

    // ---- LOAD_LAT=3: ld x5 ; add x6,x5,x0 -> three bubbles ----
    present(2, 64'h200, 5'd1, 5'd0, 5'd5, 1'b1);
    step();
    chk("l3_ld_valid", out_valid[2], 1'b1);
    present(2, 64'h204, 5'd5, 5'd0, 5'd6, 1'b0);
    #1 chk("l3_hazard_c0", hazard[2], 1'b1);
    for (int c = 1; c <= 2; c++) begin
      step();
      chk($sformatf("l3_bubble_c%0d", c), out_valid[2], 1'b0);
      chk($sformatf("l3_hazard_c%0d", c), hazard[2], 1'b1);
    end
    step();
    chk("l3_bubble_c3", out_valid[2], 1'b0);
    chk("l3_hazard_c3", hazard[2], 1'b0);
    chk("l3_ready_c3", in_ready[2], 1'b1);
    step();
    chk("l3_add_valid", out_valid[2], 1'b1);
    chk("l3_add_pc", out_pc[2], 64'h204);
    chk("l3_stall_cnt", stall_cnt[2], 32'd3);
    // load to x0 never stalls a consumer reading x0
    present(2, 64'h300, 5'd1, 5'd0, 5'd0, 1'b1);
    step();
    chk("l3_ldx0_valid", out_valid[2], 1'b1);
    present(2, 64'h304, 5'd0, 5'd3, 5'd6, 1'b0);
    #1;
    chk("l3_x0_hazard", hazard[2], 1'b0);
    chk("l3_x0_ready", in_ready[2], 1'b1);
    step();
    chk("l3_x0_add_pc", out_pc[2], 64'h304);
    chk("l3_x0_stall_cnt", stall_cnt[2], 32'd3);
    // non-load producer of x9 followed by a reader on rs2: no stall
    present(2, 64'h310, 5'd1, 5'd2, 5'd9, 1'b0);
    step();
    present(2, 64'h314, 5'd3, 5'd9, 5'd4, 1'b0);
    #1 chk("l3_alu_dep_hazard", hazard[2], 1'b0);
    step();
    chk("l3_alu_dep_pc", out_pc[2], 64'h314);
    idle(2);

    // ---- backpressure on LOAD_LAT=2 instance ----
    present(1, 64'h400, 5'd1, 5'd2, 5'd6, 1'b0);
    step();
    chk("bp_first_pc", out_pc[1], 64'h400);
    out_ready[1] = 1'b0;
    present(1, 64'h404, 5'd3, 5'd4, 5'd7, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("bp_ready_c%0d", c), in_ready[1], 1'b0);
      chk($sformatf("bp_hazard_c%0d", c), hazard[1], 1'b0);
      step();
      chk($sformatf("bp_valid_c%0d", c), out_valid[1], 1'b1);
      chk($sformatf("bp_pc_c%0d", c), out_pc[1], 64'h400);
    end
    chk("bp_stall_cnt", stall_cnt[1], 32'd0);
    out_ready[1] = 1'b1;
    #1 chk("bp_release_ready", in_ready[1], 1'b1);
    step();
    chk("bp_second_pc", out_pc[1], 64'h404);
    idle(1);

    // ---- flush with load on out and dependent consumer waiting ----
    present(1, 64'h500, 5'd1, 5'd0, 5'd5, 1'b1);
    step();
    present(1, 64'h504, 5'd5, 5'd0, 5'd6, 1'b0);
    flush[1] = 1'b1;
    #1;
    chk("fl_hazard", hazard[1], 1'b0);
    chk("fl_ready", in_ready[1], 1'b0);
    step();
    flush[1] = 1'b0;
    chk("fl_out_valid", out_valid[1], 1'b0);
    chk("fl_stall_cnt", stall_cnt[1], 32'd0);
    #1;
    chk("fl_no_pend_hazard", hazard[1], 1'b0);
    chk("fl_no_pend_ready", in_ready[1], 1'b1);
    step();
    chk("fl_consumer_pc", out_pc[1], 64'h504);
    idle(1);

    // ---- reset in the middle of a LOAD_LAT=2 stall ----
    present(1, 64'h600, 5'd1, 5'd0, 5'd5, 1'b1);
    step();
    present(1, 64'h604, 5'd5, 5'd0, 5'd6, 1'b0);
    step();
    chk("rs_stall_cnt_pre", stall_cnt[1], 32'd1);
    chk("rs_pend_hazard", hazard[1], 1'b1);
    rst = 1'b1;
    #1;
    chk("rs_hazard_in_rst", hazard[1], 1'b0);
    chk("rs_ready_in_rst", in_ready[1], 1'b0);
    step();
    rst = 1'b0;
    chk("rs_out_valid", out_valid[1], 1'b0);
    chk("rs_stall_cnt", stall_cnt[1], 32'd0);
    #1;
    chk("rs_pend_empty", hazard[1], 1'b0);
    chk("rs_ready_after", in_ready[1], 1'b1);
    step();
    chk("rs_consumer_pc", out_pc[1], 64'h604);
    chk("rs_consumer_valid", out_valid[1], 1'b1);
    idle(1);

    // ---- counter saturation on LOAD_LAT=3 instance ----
    present(2, 64'h700, 5'd1, 5'd0, 5'd5, 1'b1);
    step();
    out_ready[2] = 1'b0;
    present(2, 64'h704, 5'd5, 5'd0, 5'd6, 1'b0);
    force g_dut[2].u_dut.stall_cnt_r = 32'hFFFF_FFFD;
    #1;
    release g_dut[2].u_dut.stall_cnt_r;
    chk("sat_hazard", hazard[2], 1'b1);
    step();
    chk("sat_cnt_fe", stall_cnt[2], 32'hFFFF_FFFE);
    step();
    chk("sat_cnt_ff", stall_cnt[2], 32'hFFFF_FFFF);
    step();
    chk("sat_cnt_hold", stall_cnt[2], 32'hFFFF_FFFF);
    chk("sat_ld_held", out_pc[2], 64'h700);
    out_ready[2] = 1'b1;
    idle(2);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_issue.md
ID_EX_ISSUE -- requirements
Module: id_ex_issue

Interface
REQ-001 Parameter: XLEN, default 64, datapath width of pc/rs1/rs2/imm.
REQ-002 Parameter: LOAD_LAT, default 1, legal 1..4, load-use distance in EX-advance cycles.
REQ-003 Parameter: CTRL_W, default 12, width of the opaque decoded-control bundle.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 in_valid / in_ready  in / out  1 / 1  upstream (ID) handshake; transfer when both high.
REQ-007 in_pc, in_rs1, in_rs2, in_imm  in  XLEN each  decoded operands from ID.
REQ-008 in_ctrl  in  CTRL_W  decoded control (aluctr, src sels, jump/branch flags), passed through unmodified.
REQ-009 in_rs1_idx, in_rs2_idx, in_rd  in  5 each  source/dest register indices; index 0 means unused.
REQ-010 in_wben, in_is_load  in  1 each  writeback enable; instruction is a load.
REQ-011 flush  in  1  kill younger instructions (from branch/jump resolve in EX).
REQ-012 out_valid / out_ready  out / in  1 / 1  downstream (EX) handshake.
REQ-013 out_pc, out_rs1, out_rs2, out_imm, out_ctrl, out_rd, out_wben, out_is_load  out  widths as inputs  registered payload.
REQ-014 hazard  out  1  combinational load-use stall indication this cycle.
REQ-015 stall_cnt  out  32  count of hazard stall cycles.

Function
REQ-016 Output register is a single-entry pipeline register; load_en = out_ready | ~out_valid.
REQ-017 in_ready SHALL = load_en & ~hazard & ~flush (combinational).
REQ-018 On in_valid & in_ready: payload captured, out_valid=1 next cycle (latency 1).
REQ-019 On load_en & ~(in_valid & in_ready): out_valid=0 next cycle (bubble); payload may hold stale data.
REQ-020 On ~load_en: out register and out_valid hold unchanged.
REQ-021 Pending-load shift register pend[0..LOAD_LAT-2] of {v, rd}; absent when LOAD_LAT=1.
REQ-022 When out_ready=1: pend[0] <= {out_valid & out_is_load & out_wben & (out_rd!=0), out_rd}; pend[i] <= pend[i-1]; when out_ready=0 pend holds.
REQ-023 Hazard sources: out register (out_valid & out_is_load & out_wben, out_rd) plus every valid pend[i].
REQ-024 hazard SHALL = in_valid & ~flush & any source with rd!=0 and (rd==in_rs1_idx or rd==in_rs2_idx), ignoring index 0.
REQ-025 A load in the out register stalls a dependent consumer exactly LOAD_LAT bubbles when out_ready is held high.
REQ-026 flush=1: out_valid=0 next cycle regardless of out_ready; no input accepted; pend still shifts per REQ-022 but the flushed out-register entry is not inserted (pend[0].v=0).
REQ-027 flush and hazard in same cycle: flush dominates; hazard=0; stall_cnt unchanged.
REQ-028 stall_cnt increments by 1 each cycle hazard=1; saturates at 32'hFFFF_FFFF.
REQ-029 out payload is a pure copy; no arithmetic or sign extension inside the block.

Reset
REQ-030 rst=1 at edge: out_valid=0, all out payload=0, all pend[i].v=0 and rd=0, stall_cnt=0.
REQ-031 During rst: in_ready=0, hazard=0; rst mid-stall drops the stalled instruction and restarts clean next cycle.
REQ-032 rst has priority over flush and all handshakes.

Verification
REQ-033 LOAD_LAT=1, out_ready=1: ld x5 then add x6,x5,x7 back-to-back -> add held 1 cycle, one bubble on out, stall_cnt=1.
REQ-034 LOAD_LAT=3: ld x5, add x6,x5,x0 -> 3 bubbles, add issued on 4th cycle after load, stall_cnt=3; same with rd=x0 -> 0 bubbles.
REQ-035 Backpressure: out_ready=0 for 4 cycles with valid add on out -> out payload stable, in_ready=0, pend unchanged, stall_cnt unchanged if no dependency.
REQ-036 Flush: load in out register + dependent consumer at input, flush=1 -> out_valid=0 next cycle, hazard=0, consumer not accepted, stall_cnt unchanged.
REQ-037 Reset mid-stall (LOAD_LAT=2, after 1 stall cycle) -> next cycle out_valid=0, stall_cnt=0, pend empty, consumer accepted without stall once presented.
REQ-038 Saturation: force stall_cnt near max (long dependent stall with out_ready=0 not shifting) -> holds at 32'hFFFF_FFFF, no wrap.
